// File: rtl/multichannel_period_measure_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : theremin_sensor_pkg
// Brief   : Shared defaults and types for the theremin sensor front end
//           (period measurement and averaging).
// Revision: 1.0 - initial release
// ============================================================================
package theremin_sensor_pkg;

  // Default geometry: 64 samples per parallel clock, 16-bit raw periods,
  // 4-deep averaging window.
  localparam int c_SAMPLES_LOG2_DEFAULT = 6;
  localparam int c_PERIOD_BITS_DEFAULT  = 16;
  localparam int c_AVG_LOG2_DEFAULT     = 2;

  // Measurement mode: single half period, or two consecutive halves summed.
  typedef enum logic {MEAS_HALF, MEAS_FULL} meas_mode_t;

endpackage
`default_nettype wire

// File: rtl/multichannel_period_measure_avg_if.sv
`default_nettype none
// ============================================================================
// Module  : multichannel_period_measure_avg_if
// Brief   : Edge-report input and period/average output bundle of the
//           period measurement block.
// Revision: 1.0 - initial release
// ============================================================================
interface multichannel_period_measure_avg_if
  import theremin_sensor_pkg::*;
#(
  parameter int SAMPLES_LOG2 = c_SAMPLES_LOG2_DEFAULT,
  parameter int PERIOD_BITS  = c_PERIOD_BITS_DEFAULT,
  parameter int AVG_LOG2     = c_AVG_LOG2_DEFAULT
);
  logic                          CE;
  logic                          EDGE_FLAG;
  logic [SAMPLES_LOG2-1:0]       EDGE_BIT;
  logic                          FULL_MODE;
  logic                          RAW_VALID;
  logic [PERIOD_BITS:0]          RAW_PERIOD;
  logic                          AVG_VALID;
  logic [PERIOD_BITS+AVG_LOG2:0] AVG_SUM;
  logic                          TIMEOUT;

  // Edge detector / consumer side.
  modport master (
    output CE, EDGE_FLAG, EDGE_BIT, FULL_MODE,
    input  RAW_VALID, RAW_PERIOD, AVG_VALID, AVG_SUM, TIMEOUT
  );

  // Measurement block side.
  modport slave (
    input  CE, EDGE_FLAG, EDGE_BIT, FULL_MODE,
    output RAW_VALID, RAW_PERIOD, AVG_VALID, AVG_SUM, TIMEOUT
  );
endinterface
`default_nettype wire

// File: rtl/multichannel_period_measure_avg_moving_avg.sv
`default_nettype none
// ============================================================================
// Module  : period_moving_avg
// Brief   : Moving sum over the last 2^DEPTH_LOG2 samples using a ring buffer
//           and a running sum; output only once the window is full.
// Revision: 1.0 - initial release
// ============================================================================
module period_moving_avg #(
  parameter int WIDTH      = 17,
  parameter int DEPTH_LOG2 = 2
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        clear,
  input  wire logic                        in_valid,
  input  wire logic [WIDTH-1:0]            in_data,
  output logic                             out_valid,
  output logic [WIDTH+DEPTH_LOG2-1:0]      out_sum
);
  localparam int c_DEPTH     = 1 << DEPTH_LOG2;
  localparam int c_PTR_BITS  = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int c_FILL_BITS = DEPTH_LOG2 + 1;
  localparam int c_SUM_BITS  = WIDTH + DEPTH_LOG2;

  logic [WIDTH-1:0]       r_buf [c_DEPTH];
  logic [c_PTR_BITS-1:0]  r_wr_ptr;
  logic [c_FILL_BITS-1:0] r_fill;
  logic [c_SUM_BITS-1:0]  r_sum;
  logic [c_SUM_BITS-1:0]  r_out_sum;
  logic                   r_out_valid;

  logic [WIDTH-1:0]       w_oldest;
  logic [c_SUM_BITS-1:0]  w_sum_next;
  logic [c_FILL_BITS-1:0] w_fill_next;
  logic [c_PTR_BITS-1:0]  w_ptr_next;
  logic                   w_full_next;

  // The slot about to be overwritten holds the oldest sample (zero while
  // filling), so subtracting it keeps the running sum exact without wrap.
  assign w_oldest    = r_buf[r_wr_ptr];
  assign w_sum_next  = r_sum + c_SUM_BITS'(in_data) - c_SUM_BITS'(w_oldest);
  assign w_fill_next = (r_fill == c_FILL_BITS'(c_DEPTH)) ? r_fill
                                                         : r_fill + c_FILL_BITS'(1);
  assign w_ptr_next  = (r_wr_ptr == c_PTR_BITS'(c_DEPTH - 1)) ? '0
                                                              : r_wr_ptr + c_PTR_BITS'(1);
  assign w_full_next = (w_fill_next == c_FILL_BITS'(c_DEPTH));

  // Ring buffer, running sum and fill counter; clear restarts the window but
  // leaves the last published sum untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) r_buf[i] <= '0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_out_sum   <= '0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < c_DEPTH; i++) r_buf[i] <= '0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_buf[r_wr_ptr] <= in_data;
      r_wr_ptr        <= w_ptr_next;
      r_fill          <= w_fill_next;
      r_sum           <= w_sum_next;
      r_out_valid     <= w_full_next;
      if (w_full_next) r_out_sum <= w_sum_next;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
endmodule
`default_nettype wire

// File: rtl/multichannel_period_measure_avg.sv
`default_nettype none
// ============================================================================
// Module  : multichannel_period_measure_avg
// Brief   : Converts per-cycle oversampled edge reports into half/full period
//           measurements in samples, with signal-loss timeout and a moving
//           sum over the last 2^AVG_LOG2 measurements.
// Revision: 1.0 - initial release
// ============================================================================
module multichannel_period_measure_avg
  import theremin_sensor_pkg::*;
#(
  parameter int SAMPLES_LOG2 = c_SAMPLES_LOG2_DEFAULT,
  parameter int PERIOD_BITS  = c_PERIOD_BITS_DEFAULT,
  parameter int AVG_LOG2     = c_AVG_LOG2_DEFAULT
) (
  input  wire logic                      CLK_PARALLEL,
  input  wire logic                      RESET_N,
  multichannel_period_measure_avg_if.slave bus
);
  typedef enum logic {PHASE_A, PHASE_B} pair_phase_t;

  localparam int                     c_S       = 1 << SAMPLES_LOG2;
  localparam logic [PERIOD_BITS-1:0] c_ACC_MAX = '1;

  logic [PERIOD_BITS-1:0]  r_acc;
  logic                    r_timeout;
  meas_mode_t              r_mode;
  pair_phase_t             r_phase;
  pair_phase_t             w_phase_next;
  logic [PERIOD_BITS-1:0]  r_stored;
  logic                    r_raw_valid;
  logic [PERIOD_BITS:0]    r_raw_period;

  logic                    w_edge;
  meas_mode_t              w_mode_in;
  logic                    w_restart;
  logic [PERIOD_BITS:0]    w_acc_inc;
  logic                    w_sat;
  logic [PERIOD_BITS:0]    w_half_wide;
  logic [PERIOD_BITS-1:0]  w_half;
  logic [SAMPLES_LOG2-1:0] w_edge_bit_inv;
  logic [PERIOD_BITS-1:0]  w_reload;
  logic [PERIOD_BITS:0]    w_pair_sum;
  logic                    w_clear;
  logic                    w_emit;
  logic                    w_store;
  logic [PERIOD_BITS:0]    w_emit_val;
  logic                    w_avg_valid;
  logic [PERIOD_BITS+AVG_LOG2:0] w_avg_sum;

  assign w_edge    = bus.CE & bus.EDGE_FLAG;
  assign w_mode_in = bus.FULL_MODE ? MEAS_FULL : MEAS_HALF;
  assign w_restart = bus.CE & (w_mode_in != r_mode);

  // Accumulator advance with one carry bit to detect saturation.
  assign w_acc_inc = {1'b0, r_acc} + (PERIOD_BITS+1)'(c_S);
  assign w_sat     = w_acc_inc[PERIOD_BITS];

  // Samples from the previous edge up to and including this edge's sample;
  // clamps instead of wrapping when the accumulator sat at full scale.
  assign w_half_wide = {1'b0, r_acc} + (PERIOD_BITS+1)'(bus.EDGE_BIT) + (PERIOD_BITS+1)'(1);
  assign w_half      = w_half_wide[PERIOD_BITS] ? c_ACC_MAX : w_half_wide[PERIOD_BITS-1:0];

  // Samples remaining after the edge in this cycle: S-1-b.
  assign w_edge_bit_inv = ~bus.EDGE_BIT;
  assign w_reload       = {{(PERIOD_BITS-SAMPLES_LOG2){1'b0}}, w_edge_bit_inv};

  assign w_pair_sum = {1'b0, r_stored} + {1'b0, w_half};

  // Averaging window restarts on mode change, on recovery from timeout and
  // while the accumulator is saturated.
  assign w_clear = bus.CE & (w_restart | (w_edge & r_timeout) | (~bus.EDGE_FLAG & w_sat));

  // Half/full pairing: decide whether this edge emits, stores a first half,
  // or is discarded; a mode change forces the edge to start a new pair.
  always_comb begin
    w_phase_next = r_phase;
    w_emit       = 1'b0;
    w_store      = 1'b0;
    w_emit_val   = {1'b0, w_half};
    if (bus.CE) begin
      if (w_restart) w_phase_next = PHASE_A;
      if (w_edge) begin
        if (r_timeout) begin
          w_phase_next = PHASE_A;
        end else if (w_mode_in == MEAS_HALF) begin
          w_emit       = 1'b1;
          w_phase_next = PHASE_A;
        end else if (w_restart || (r_phase == PHASE_A)) begin
          w_store      = 1'b1;
          w_phase_next = PHASE_B;
        end else begin
          w_emit       = 1'b1;
          w_emit_val   = w_pair_sum;
          w_phase_next = PHASE_A;
        end
      end
    end
  end

  // Pairing phase register.
  always_ff @(posedge CLK_PARALLEL or negedge RESET_N) begin
    if (!RESET_N) r_phase <= PHASE_A;
    else          r_phase <= w_phase_next;
  end

  // Accumulator, timeout flag, mode register, stored half and raw output.
  always_ff @(posedge CLK_PARALLEL or negedge RESET_N) begin
    if (!RESET_N) begin
      r_acc        <= '0;
      r_timeout    <= 1'b0;
      r_mode       <= MEAS_HALF;
      r_stored     <= '0;
      r_raw_valid  <= 1'b0;
      r_raw_period <= '0;
    end else if (!bus.CE) begin
      r_raw_valid <= 1'b0;
    end else begin
      r_mode      <= w_mode_in;
      r_raw_valid <= w_emit;
      if (w_emit)  r_raw_period <= w_emit_val;
      if (w_store) r_stored     <= w_half;
      if (bus.EDGE_FLAG) begin
        r_acc     <= w_reload;
        r_timeout <= 1'b0;
      end else if (w_sat) begin
        r_acc     <= c_ACC_MAX;
        r_timeout <= 1'b1;
      end else begin
        r_acc <= w_acc_inc[PERIOD_BITS-1:0];
      end
    end
  end

  period_moving_avg #(
    .WIDTH      (PERIOD_BITS + 1),
    .DEPTH_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (CLK_PARALLEL),
    .rst_n     (RESET_N),
    .clear     (w_clear),
    .in_valid  (r_raw_valid),
    .in_data   (r_raw_period),
    .out_valid (w_avg_valid),
    .out_sum   (w_avg_sum)
  );

  assign bus.RAW_VALID  = r_raw_valid;
  assign bus.RAW_PERIOD = r_raw_period;
  assign bus.AVG_VALID  = w_avg_valid;
  assign bus.AVG_SUM    = w_avg_sum;
  assign bus.TIMEOUT    = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_multichannel_period_measure_avg.sv
`default_nettype none
// ============================================================================
// Module  : tb_multichannel_period_measure_avg
// Brief   : Self-checking bench: sample-position reference model plus
//           directed scenarios and randomized edge streams.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multichannel_period_measure_avg;
  localparam int SL   = 6;
  localparam int PB   = 16;
  localparam int AL   = 2;
  localparam int N    = 1 << AL;
  localparam int S    = 1 << SL;
  localparam int MAXV = (1 << PB) - 1;

  logic CLK_PARALLEL = 1'b0;
  logic RESET_N      = 1'b0;
  always #5 CLK_PARALLEL = ~CLK_PARALLEL;

  multichannel_period_measure_avg_if #(.SAMPLES_LOG2(SL), .PERIOD_BITS(PB), .AVG_LOG2(AL)) bus_if ();

  multichannel_period_measure_avg #(.SAMPLES_LOG2(SL), .PERIOD_BITS(PB), .AVG_LOG2(AL)) dut (
    .CLK_PARALLEL (CLK_PARALLEL),
    .RESET_N      (RESET_N),
    .bus          (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: edges as absolute sample positions counted over
  // enabled cycles only; a half period is the distance between positions.
  int m_c, m_last, m_stored;
  bit m_to, m_mode, m_pend;
  int m_win[$];
  bit e_rv, e_av, e_to, n_rv, n_av;
  int e_rp, e_as, n_rp, n_as;

  int raw_pulses = 0, avg_pulses = 0, last_raw = 0, last_avg = 0, first_avg_at_raw = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_last = -1; m_stored = 0;
    m_to = 0; m_mode = 0; m_pend = 0;
    m_win.delete();
    e_rv = 0; e_av = 0; e_to = 0; e_rp = 0; e_as = 0;
  endtask

  task automatic model_step(input bit ce, input bit ef, input int eb, input bit fm);
    bit clr;
    int pos, half, sum;
    clr = 0; n_rv = 0; n_av = 0; n_rp = e_rp; n_as = e_as;
    if (ce) begin
      if (fm != m_mode) begin m_mode = fm; m_pend = 0; clr = 1; end
      pos = S * m_c + eb;
      if (ef) begin
        if (m_to) begin
          m_to = 0; m_pend = 0; clr = 1; m_last = pos;
        end else begin
          half = pos - m_last;
          if (half > MAXV) half = MAXV;
          m_last = pos;
          if (!m_mode) begin n_rv = 1; n_rp = half; end
          else if (!m_pend) begin m_stored = half; m_pend = 1; end
          else begin n_rv = 1; n_rp = m_stored + half; m_pend = 0; end
        end
      end else if (m_to || (S * m_c + (S - 1) - m_last > MAXV)) begin
        m_to = 1; clr = 1;
      end
      m_c++;
    end
    // The measurement currently on the output enters the window this cycle.
    if (clr) m_win.delete();
    else if (e_rv) begin
      m_win.push_back(e_rp);
      if (m_win.size() > N) void'(m_win.pop_front());
      if (m_win.size() == N) begin
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        n_av = 1; n_as = sum;
      end
    end
  endtask

  task automatic tick(input bit ce, input bit ef, input int eb, input bit fm);
    bus_if.CE        = ce;
    bus_if.EDGE_FLAG = ef;
    bus_if.EDGE_BIT  = SL'(eb);
    bus_if.FULL_MODE = fm;
    model_step(ce, ef, eb, fm);
    @(posedge CLK_PARALLEL);
    #1;
    e_rv = n_rv; e_rp = n_rp; e_av = n_av; e_as = n_as; e_to = m_to;
    chk("raw_valid",  bus_if.RAW_VALID,  e_rv);
    chk("raw_period", bus_if.RAW_PERIOD, e_rp);
    chk("avg_valid",  bus_if.AVG_VALID,  e_av);
    chk("avg_sum",    bus_if.AVG_SUM,    e_as);
    chk("timeout",    bus_if.TIMEOUT,    e_to);
    if (bus_if.RAW_VALID === 1'b1) begin raw_pulses++; last_raw = int'(bus_if.RAW_PERIOD); end
    if (bus_if.AVG_VALID === 1'b1) begin
      avg_pulses++; last_avg = int'(bus_if.AVG_SUM);
      if (first_avg_at_raw == 0) first_avg_at_raw = raw_pulses;
    end
  endtask

  // Edge with bit b now, then (gap-1) idle cycles; the next edge lands gap
  // cycles later.  Bit index during idle cycles is random and must be ignored.
  task automatic run_edge(input int gap, input int b, input bit fm);
    tick(1, 1, b, fm);
    repeat (gap - 1) tick(1, 0, $urandom_range(0, S - 1), fm);
  endtask

  initial begin
    int p0, a0, k, b, gap;
    bit cur_fm;
    bus_if.CE = 0; bus_if.EDGE_FLAG = 0; bus_if.EDGE_BIT = '0; bus_if.FULL_MODE = 0;
    model_reset();
    repeat (3) @(posedge CLK_PARALLEL);
    #1;
    chk("reset_raw_valid",  bus_if.RAW_VALID,  0);
    chk("reset_raw_period", bus_if.RAW_PERIOD, 0);
    chk("reset_avg_valid",  bus_if.AVG_VALID,  0);
    chk("reset_avg_sum",    bus_if.AVG_SUM,    0);
    chk("reset_timeout",    bus_if.TIMEOUT,    0);
    RESET_N = 1'b1;
    model_reset();
    repeat (3) tick(1, 0, 0, 0);

    // Half mode, steady 10-cycle period at bit 5.
    repeat (6) run_edge(10, 5, 0);
    chk("half_raw", last_raw, 640);
    chk("half_avg", last_avg, 2560);
    chk("first_avg_on_4th_raw", first_avg_at_raw, 4);

    // Full mode, alternating 10/6-cycle halves; every adjacent pair sums to 1024.
    p0 = raw_pulses;
    repeat (5) begin run_edge(10, 5, 1); run_edge(6, 2, 1); end
    chk("full_pair_count", raw_pulses, p0 + 5);
    chk("full_raw", last_raw, 1024);
    chk("full_avg", last_avg, 4096);

    // Signal loss, discarded recovery edge, then refill of the window.
    tick(1, 0, 0, 0);
    repeat (1100) tick(1, 0, $urandom_range(0, S - 1), 0);
    chk("timeout_set", bus_if.TIMEOUT, 1);
    p0 = raw_pulses; a0 = avg_pulses;
    run_edge(10, 5, 0);
    chk("timeout_discard", raw_pulses, p0);
    chk("timeout_clear", bus_if.TIMEOUT, 0);
    repeat (3) run_edge(10, 5, 0);
    chk("refill_wait", avg_pulses, a0);
    run_edge(10, 5, 0);
    chk("refill_avg_count", avg_pulses, a0 + 1);
    chk("refill_raw", last_raw, 640);
    chk("refill_avg", last_avg, 2560);

    // Mode toggle mid-stream: four full-mode values before the next average.
    a0 = avg_pulses;
    repeat (7) run_edge(10, 5, 1);
    chk("toggle_wait", avg_pulses, a0);
    run_edge(10, 5, 1);
    chk("toggle_avg_count", avg_pulses, a0 + 1);
    chk("toggle_raw", last_raw, 1280);
    chk("toggle_avg", last_avg, 5120);

    // Clock-enable freeze between edges; edges offered while frozen are ignored.
    repeat (2) run_edge(10, 5, 0);
    tick(1, 1, 5, 0);
    repeat (4) tick(1, 0, 0, 0);
    repeat (7) tick(0, $urandom_range(0, 1), $urandom_range(0, S - 1), $urandom_range(0, 1));
    repeat (5) tick(1, 0, 0, 0);
    tick(1, 1, 5, 0);
    tick(1, 0, 0, 0);
    chk("ce_freeze_raw", last_raw, 640);

    // Randomized stream: gaps, bit positions, enable gaps, occasional mode flips.
    cur_fm = 0;
    for (int n = 0; n < 250; n++) begin
      gap = $urandom_range(1, 40);
      b   = $urandom_range(0, S - 1);
      if ($urandom_range(0, 15) == 0) cur_fm = ~cur_fm;
      if (n == 120) repeat (1100) tick(1, 0, 0, cur_fm);
      for (int i = 0; i < gap; i++)
        tick($urandom_range(0, 7) != 0, i == 0, (i == 0) ? b : $urandom_range(0, S - 1), cur_fm);
    end

    // Asynchronous reset mid-window, then measurement from release.
    run_edge(10, 5, 0);
    tick(1, 1, 9, 0);
    tick(1, 0, 0, 0);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_raw_valid",  bus_if.RAW_VALID,  0);
    chk("async_raw_period", bus_if.RAW_PERIOD, 0);
    chk("async_avg_valid",  bus_if.AVG_VALID,  0);
    chk("async_avg_sum",    bus_if.AVG_SUM,    0);
    chk("async_timeout",    bus_if.TIMEOUT,    0);
    @(posedge CLK_PARALLEL);
    #1 RESET_N = 1'b1;
    model_reset();
    k = $urandom_range(3, 20);
    b = $urandom_range(0, S - 1);
    repeat (k) tick(1, 0, 0, 0);
    tick(1, 1, b, 0);
    tick(1, 0, 0, 0);
    chk("post_reset_raw", last_raw, k * S + b + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
